// File: rtl/meas_cycle_ctrl.sv
// Measurement cycle sequencer: arms the timebase divider, waits out a settle
// period, gates acquisition for a window of ticks, then hands off to readout.
module meas_cycle_ctrl #(
  parameter logic [15:0] TICK_TIMEOUT = 16'd64000
) (
  input  logic        clk_12mhz,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  cfg_settle,
  input  logic [15:0] cfg_window,
  input  logic        rd_ack,
  output logic        div_reset,
  output logic        busy,
  output logic        acq_en,
  output logic [15:0] win_count,
  output logic        rd_req,
  output logic        done,
  output logic        aborted,
  output logic        tick_err,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SETTLE  = 3'd2,
    S_ACQ     = 3'd3,
    S_READOUT = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t      state, nxt;
  logic [2:0]  tick_sync;
  logic        tick;
  logic [7:0]  settle_lat, settle_cnt;
  logic [15:0] win_lat;
  logic [15:0] wd_cnt;
  logic        wd_expired;
  logic [8:0]  settle_inc;
  logic [16:0] win_inc;
  logic        settle_hit, win_hit, in_cycle, timed_state;

  // Two sync flops plus an edge register; either polarity of tick_in is a tick.
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) tick_sync <= 3'b000;
    else       tick_sync <= {tick_sync[1:0], tick_in};
  end

  assign tick       = tick_sync[2] ^ tick_sync[1];
  assign settle_inc = {1'b0, settle_cnt} + 9'd1;
  assign win_inc    = {1'b0, win_count} + 17'd1;
  assign settle_hit = (settle_inc == {1'b0, settle_lat});
  assign win_hit    = (win_inc == {1'b0, win_lat});
  assign wd_expired = (wd_cnt == TICK_TIMEOUT);
  assign in_cycle   = (state == S_ARM) || (state == S_SETTLE) ||
                      (state == S_ACQ) || (state == S_READOUT);
  assign timed_state = (state == S_SETTLE) || (state == S_ACQ);

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Abort outranks everything; a tick outranks a coincident watchdog expiry.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (start) nxt = S_ARM;
      S_ARM: begin
        if (abort)                 nxt = S_IDLE;
        else if (settle_lat != '0) nxt = S_SETTLE;
        else                       nxt = S_ACQ;
      end
      S_SETTLE: begin
        if (abort)             nxt = S_IDLE;
        else if (tick)         nxt = settle_hit ? S_ACQ : S_SETTLE;
        else if (wd_expired)   nxt = S_ERROR;
      end
      S_ACQ: begin
        if (abort)             nxt = S_IDLE;
        else if (tick)         nxt = win_hit ? S_READOUT : S_ACQ;
        else if (wd_expired)   nxt = S_ERROR;
      end
      S_READOUT: if (abort || rd_ack) nxt = S_IDLE;
      S_ERROR:   if (abort) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    div_reset = 1'b1;
    busy      = 1'b1;
    acq_en    = 1'b0;
    rd_req    = 1'b0;
    case (state)
      S_IDLE:   busy = 1'b0;
      S_ARM, S_SETTLE: div_reset = 1'b0;
      S_ACQ: begin
        div_reset = 1'b0;
        acq_en    = 1'b1;
      end
      S_READOUT: rd_req = 1'b1;
      default: ;
    endcase
  end

  // Cycle configuration and tick counters.
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      settle_lat <= '0;
      win_lat    <= 16'd1;
      settle_cnt <= '0;
      win_count  <= '0;
    end else if (state == S_IDLE && start) begin
      settle_lat <= cfg_settle;
      win_lat    <= (cfg_window == '0) ? 16'd1 : cfg_window;
      settle_cnt <= '0;
      win_count  <= '0;
    end else if (tick && !abort) begin
      if (state == S_SETTLE && !settle_inc[8])
        settle_cnt <= settle_inc[7:0];
      if (state == S_ACQ && !win_inc[16])
        win_count <= win_inc[15:0];
    end
  end

  // Watchdog restarts on each tick and on every entry into SETTLE or ACQ.
  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset)
      wd_cnt <= '0;
    else if (!timed_state || nxt != state || tick)
      wd_cnt <= '0;
    else if (!wd_expired)
      wd_cnt <= wd_cnt + 16'd1;
  end

  always_ff @(posedge clk_12mhz or posedge reset) begin
    if (reset) begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      overrun  <= 1'b0;
      tick_err <= 1'b0;
    end else begin
      done    <= (state == S_READOUT) && rd_ack && !abort;
      aborted <= in_cycle && abort;
      overrun <= start && busy && (state != S_READOUT);
      if (state == S_IDLE && start)
        tick_err <= 1'b0;
      else if (nxt == S_ERROR && state != S_ERROR)
        tick_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_meas_cycle_ctrl.sv
// Randomized and directed bench for meas_cycle_ctrl against a cycle-level
// behavioural model of the measurement sequence.
module tb_meas_cycle_ctrl;

  localparam int TO = 400;

  logic        clk_12mhz = 1'b0;
  logic        reset, tick_in, start, abort, rd_ack;
  logic [7:0]  cfg_settle;
  logic [15:0] cfg_window;
  logic        div_reset, busy, acq_en, rd_req, done, aborted, tick_err, overrun;
  logic [15:0] win_count;

  meas_cycle_ctrl #(.TICK_TIMEOUT(16'(TO))) dut (
    .clk_12mhz(clk_12mhz), .reset(reset), .tick_in(tick_in), .start(start),
    .abort(abort), .cfg_settle(cfg_settle), .cfg_window(cfg_window),
    .rd_ack(rd_ack), .div_reset(div_reset), .busy(busy), .acq_en(acq_en),
    .win_count(win_count), .rd_req(rd_req), .done(done), .aborted(aborted),
    .tick_err(tick_err), .overrun(overrun)
  );

  always #5 clk_12mhz = ~clk_12mhz;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model: phase of the measurement cycle and its bookkeeping.
  localparam int P_IDLE = 0, P_ARM = 1, P_SETTLE = 2, P_ACQ = 3, P_READOUT = 4, P_ERROR = 5;
  int  phase, set_tgt, win_tgt, set_seen, win_seen, cyc_n, last_ev;
  bit  m_done, m_ab, m_ov, m_err;
  bit  h1, h2, h3;
  int  tick_per, tick_ctr;
  bit  tick_run;

  task automatic model_reset();
    phase = P_IDLE; set_tgt = 0; win_tgt = 1; set_seen = 0; win_seen = 0;
    m_done = 0; m_ab = 0; m_ov = 0; m_err = 0; h1 = 0; h2 = 0; h3 = 0; last_ev = cyc_n;
  endtask

  // Advance the model by one clock using the inputs about to be sampled.
  task automatic model_step();
    bit tk;
    cyc_n++;
    tk = h2 ^ h3;
    h3 = h2; h2 = h1; h1 = tick_in;
    m_done = 0; m_ab = 0;
    m_ov = start && phase != P_IDLE && phase != P_READOUT;
    if (abort && phase inside {P_ARM, P_SETTLE, P_ACQ, P_READOUT}) begin
      m_ab = 1; phase = P_IDLE;
    end else begin
      case (phase)
        P_IDLE: if (start) begin
          set_tgt = cfg_settle; win_tgt = (cfg_window == 0) ? 1 : cfg_window;
          set_seen = 0; win_seen = 0; m_err = 0; phase = P_ARM;
        end
        P_ARM: begin
          phase = (set_tgt > 0) ? P_SETTLE : P_ACQ; last_ev = cyc_n;
        end
        P_SETTLE, P_ACQ: begin
          if (tk) begin
            last_ev = cyc_n;
            if (phase == P_SETTLE) begin
              set_seen++;
              if (set_seen == set_tgt) phase = P_ACQ;
            end else begin
              win_seen++;
              if (win_seen == win_tgt) phase = P_READOUT;
            end
          end else if (cyc_n - 1 - last_ev == TO) begin
            phase = P_ERROR; m_err = 1;
          end
        end
        P_READOUT: if (rd_ack) begin m_done = 1; phase = P_IDLE; end
        P_ERROR:   if (abort) phase = P_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic cmp_all();
    chk("div_reset", div_reset, phase inside {P_IDLE, P_READOUT, P_ERROR});
    chk("busy",      busy,      phase != P_IDLE);
    chk("acq_en",    acq_en,    phase == P_ACQ);
    chk("rd_req",    rd_req,    phase == P_READOUT);
    chk("win_count", win_count, win_seen);
    chk("done",      done,      m_done);
    chk("aborted",   aborted,   m_ab);
    chk("overrun",   overrun,   m_ov);
    chk("tick_err",  tick_err,  m_err);
  endtask

  // One clock: drive at the falling edge, step the model, compare at the next falling edge.
  task automatic cyc(input bit st, input bit ab, input bit ack,
                     input logic [7:0] cs, input logic [15:0] cw);
    start = st; abort = ab; rd_ack = ack; cfg_settle = cs; cfg_window = cw;
    if (tick_run) begin
      tick_ctr++;
      if (tick_ctr >= tick_per) begin tick_ctr = 0; tick_in = ~tick_in; end
    end
    model_step();
    @(posedge clk_12mhz);
    @(negedge clk_12mhz);
    cmp_all();
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'd0, 16'd0);
  endtask

  initial begin
    reset = 1; tick_in = 0; start = 0; abort = 0; rd_ack = 0;
    cfg_settle = 0; cfg_window = 0;
    cyc_n = 0; tick_per = 20; tick_ctr = 0; tick_run = 1;
    model_reset();
    @(negedge clk_12mhz); @(negedge clk_12mhz);
    cmp_all();
    reset = 0;
    idle_n(3);

    // settle=2, window=3: full cycle through readout and done.
    cyc(1, 0, 0, 8'd2, 16'd3);
    for (int i = 0; i < 400 && phase != P_READOUT; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    chk("d1_rd_req", rd_req, 1);
    chk("d1_win", win_count, 3);
    idle_n(2);
    cyc(0, 0, 1, 8'd0, 16'd0);
    chk("d1_done", done, 1);
    idle_n(3);

    // settle=0, window=0: straight to ACQ, readout after a single tick.
    cyc(1, 0, 0, 8'd0, 16'd0);
    cyc(0, 0, 0, 8'd0, 16'd0);
    chk("d2_acq_direct", acq_en, 1);
    for (int i = 0; i < 200 && phase != P_READOUT; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    chk("d2_win1", win_count, 1);
    cyc(0, 0, 1, 8'd0, 16'd0);

    // Abort during ACQ at win_count 5.
    tick_per = 6;
    cyc(1, 0, 0, 8'd1, 16'd10);
    for (int i = 0; i < 400 && !(phase == P_ACQ && win_seen == 5); i++) cyc(0, 0, 0, 8'd0, 16'd0);
    chk("d3_win5", win_count, 5);
    cyc(0, 1, 0, 8'd0, 16'd0);
    chk("d3_aborted", aborted, 1);
    chk("d3_divrst", div_reset, 1);
    idle_n(2);

    // Timebase lost in ACQ: watchdog into ERROR, start ignored, abort recovers.
    cyc(1, 0, 0, 8'd0, 16'd9);
    for (int i = 0; i < 200 && win_seen < 2; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    tick_run = 0;
    for (int i = 0; i < TO + 100 && phase != P_ERROR; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    chk("d4_tick_err", tick_err, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 8'd1, 16'd1);
    chk("d4_stay_err", busy, 1);
    cyc(0, 1, 0, 8'd0, 16'd0);
    chk("d4_idle", busy, 0);
    tick_run = 1;
    cyc(1, 0, 0, 8'd1, 16'd1);
    chk("d4_err_clr", tick_err, 0);
    for (int i = 0; i < 100 && phase != P_READOUT; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    cyc(0, 0, 1, 8'd0, 16'd0);

    // Start held through SETTLE: overrun every cycle, then reset mid-ACQ.
    tick_per = 15;
    cyc(1, 0, 0, 8'd3, 16'd4);
    for (int i = 0; i < 30; i++) cyc(1, 0, 0, 8'd0, 16'd0);
    chk("d5_overrun", overrun, 1);
    for (int i = 0; i < 300 && phase != P_ACQ; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    reset = 1;
    model_reset();
    #1;
    cmp_all();
    @(negedge clk_12mhz);
    cmp_all();
    reset = 0;
    idle_n(3);

    // rd_ack with abort in READOUT: abort wins.
    cyc(1, 0, 0, 8'd0, 16'd1);
    for (int i = 0; i < 200 && phase != P_READOUT; i++) cyc(0, 0, 0, 8'd0, 16'd0);
    cyc(0, 1, 1, 8'd0, 16'd0);
    chk("d6_aborted", aborted, 1);
    chk("d6_no_done", done, 0);

    // Random traffic, including occasional timebase stalls.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) == 0)
        tick_per = ($urandom_range(0, 9) == 0) ? TO + 200 : int'($urandom_range(3, 30));
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
          $urandom_range(0, 3) == 0, 8'($urandom_range(0, 3)),
          16'($urandom_range(0, 4)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/meas_cycle_ctrl.md
MEAS_CYCLE_CTRL -- requirements
Module: meas_cycle_ctrl

Interface
REQ-001 Parameter: TICK_TIMEOUT, 16'd64000, max clk_12mhz cycles allowed between timebase ticks (nominal 60000).
REQ-002 clk_12mhz  input  1  system clock, 12 MHz.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 tick_in  input  1  5 ms timebase from divider chain (toggles every 5 ms), asynchronous to clk_12mhz.
REQ-005 start  input  1  cycle request, level, sampled on clk_12mhz.
REQ-006 abort  input  1  cancel request, level, sampled on clk_12mhz.
REQ-007 cfg_settle  input  8  settle length in ticks, latched at start.
REQ-008 cfg_window  input  16  acquisition length in ticks, latched at start.
REQ-009 rd_ack  input  1  readout consumer acknowledge.
REQ-010 div_reset  output  1  reset to divider chain; high holds timebase in phase-zero.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 acq_en  output  1  acquisition gate, high only in ACQ.
REQ-013 win_count  output  16  ticks elapsed in current acquisition window.
REQ-014 rd_req  output  1  readout request, high only in READOUT.
REQ-015 done  output  1  one-cycle pulse on completed cycle.
REQ-016 aborted  output  1  one-cycle pulse on abort-terminated cycle.
REQ-017 tick_err  output  1  sticky timebase-lost flag.
REQ-018 overrun  output  1  one-cycle pulse when start is high while busy outside READOUT.

Function
REQ-019 tick_in SHALL pass a 2-FF synchronizer plus edge register; each rising or falling edge SHALL yield a one-cycle internal tick 3 clk_12mhz cycles after the edge.
REQ-020 States SHALL be IDLE, ARM, SETTLE, ACQ, READOUT, ERROR, encoded in a single state register.
REQ-021 IDLE: div_reset=1; start=1 -> latch cfg_settle/cfg_window, clear win_count, go ARM.
REQ-022 ARM: div_reset=0, one cycle; next SETTLE if latched settle>0, else ACQ.
REQ-023 SETTLE: count internal ticks; on tick making count equal latched settle -> ACQ.
REQ-024 ACQ: acq_en=1; win_count +1 per tick; on tick making win_count equal latched window -> READOUT, win_count held.
REQ-025 Latched window value 0 SHALL be treated as 1.
REQ-026 READOUT: rd_req=1 and div_reset=1; on rd_ack=1 -> IDLE with done=1 for that cycle; rd_ack outside READOUT ignored.
REQ-027 abort=1 in ARM, SETTLE, ACQ or READOUT SHALL -> IDLE next cycle with aborted=1, done=0; abort has priority over every other transition in the same cycle.
REQ-028 Watchdog counter SHALL clear on every internal tick and on entry to SETTLE/ACQ; in SETTLE or ACQ reaching TICK_TIMEOUT -> ERROR.
REQ-029 ERROR: div_reset=1, tick_err=1, acq_en=0; exit to IDLE only on abort; start ignored.
REQ-030 tick_err SHALL clear on next accepted start from IDLE.
REQ-031 start in IDLE takes priority over nothing else; a start held high after done SHALL launch a new cycle on the following cycle (level semantics).
REQ-032 Tick coincident with abort SHALL not increment any counter.
REQ-033 Counters SHALL not wrap: win_count max 65535 equals max window.

Reset
REQ-034 On reset: state IDLE, div_reset=1, busy=0, acq_en=0, rd_req=0, done=0, aborted=0, overrun=0, tick_err=0, win_count=0, synchronizer and watchdog cleared.
REQ-035 Reset mid-cycle SHALL discard the cycle without done or aborted pulse.

Verification
REQ-036 settle=2, window=3, tick_in toggling every 60000 cycles after div_reset falls -> acq_en high from tick 2 to tick 5 (+3 cycles), win_count 1,2,3, rd_req rises; rd_ack -> done one cycle, IDLE.
REQ-037 settle=0, window=0 -> ARM goes directly to ACQ; READOUT after first tick, win_count=1.
REQ-038 abort asserted in ACQ at win_count=5 -> IDLE next cycle, aborted=1 one cycle, done=0, div_reset=1.
REQ-039 tick_in stuck after entering ACQ -> ERROR at 64000 cycles after last tick, tick_err=1; start ignored; abort -> IDLE; next start clears tick_err.
REQ-040 start held high during SETTLE -> overrun pulse each cycle, no restart; reset asserted in ACQ -> all outputs at reset values immediately.
REQ-041 rd_ack and abort simultaneous in READOUT -> aborted=1, done=0.
